// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU data-memory responder.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_DEF       = 64;
    localparam int WAIT_CYCLES_DEF = 2;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(DEPTH_DEF);

    // Replace only the bytes of old_word whose enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with byte-enabled synchronous write and a registered,
// clearable read port. Contents are deliberately not reset.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             we,
    input  logic             re,
    input  logic             clr,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Array write port.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[idx] <= be_merge(mem_r[idx], wdata, be);
        end
    end

    // Read register: loads on a read, clears on a faulted access, else holds.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= mem_r[idx];
        end else if (clr) begin
            rdata_r <= 32'h0000_0000;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request, waits WAIT_CYCLES, then acks
// for one cycle with read data or an access fault.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          IDX_W     = idx_width(DEPTH);
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic        we_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  be_r;
    logic        busy_r, ack_r, err_r;

    logic        acc_we_s;
    logic [31:0] acc_addr_s, acc_wdata_s;
    logic [3:0]  acc_be_s;
    logic        fault_s, enter_resp_s;

    // With zero wait states RESP is entered on the capture edge itself, so the
    // access is evaluated from the live inputs while idle.
    assign acc_we_s    = (state_r == IDLE) ? we    : we_r;
    assign acc_addr_s  = (state_r == IDLE) ? addr  : addr_r;
    assign acc_wdata_s = (state_r == IDLE) ? wdata : wdata_r;
    assign acc_be_s    = (state_r == IDLE) ? be    : be_r;

    assign fault_s      = (acc_addr_s[1:0] != 2'b00) || (acc_addr_s[31:2] >= DEPTH_W);
    assign enter_resp_s = (state_next_s == RESP);

    // Next-state and wait counter.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s != IDLE);
            ack_r   <= enter_resp_s;
            err_r   <= enter_resp_s && fault_s;
        end
    end

    // Request capture; only an idle responder accepts a new access.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'h0;
        end else if ((state_r == IDLE) && req) begin
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
            be_r    <= be;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .CLK   (CLK),
        .RST   (RST),
        .we    (enter_resp_s && acc_we_s && !fault_s),
        .re    (enter_resp_s && !acc_we_s && !fault_s),
        .clr   (enter_resp_s && fault_s),
        .idx   (acc_addr_s[IDX_W+1:2]),
        .wdata (acc_wdata_s),
        .be    (acc_be_s),
        .rdata (rdata)
    );

    assign busy = busy_r;
    assign ack  = ack_r;
    assign err  = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req = 1'b0, req0 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic        busy, ack, err, busy0, ack0, err0;
    logic [31:0] rdata, rdata0;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [31:0] mem_m [64];
    logic [31:0] last_rd;

    always #5 CLK = ~CLK;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .busy(busy), .ack(ack), .rdata(rdata), .err(err)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(RST), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= 64);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r = r | ((b[i] ? n : o) & (32'hFF << (8 * i)));
        end
        return r;
    endfunction

    // One request, then an 8-cycle observation window (cycle k = cycle after edge E0+k).
    task automatic access(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output int lat, output int bcnt, output int acnt,
                          output int errx, output logic [31:0] rd, output logic e);
        logic sb, sa, se;
        we = w; addr = a; wdata = d; be = b;
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(posedge CLK); #1;
        req = 1'b0; req0 = 1'b0;
        lat = -1; bcnt = 0; acnt = 0; errx = 0; rd = 32'h0; e = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sb = sel ? busy0 : busy;
            sa = sel ? ack0  : ack;
            se = sel ? err0  : err;
            if (sb) bcnt++;
            if (sa) begin
                acnt++;
                if (lat < 0) begin
                    lat = k; rd = sel ? rdata0 : rdata; e = se;
                end
            end else if (se) begin
                errx++;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        cmp_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        cmp_cnt++; if (ack !== 1'b0) begin fail_cnt++; $display("FAIL reset_ack: got %b want 0", ack); end
        cmp_cnt++; if (err !== 1'b0) begin fail_cnt++; $display("FAIL reset_err: got %b want 0", err); end
        cmp_cnt++; if (rdata !== 32'h0) begin fail_cnt++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        cmp_cnt++; if ({busy0, ack0, err0} !== 3'b000) begin fail_cnt++; $display("FAIL reset_wc0: got %b want 000", {busy0, ack0, err0}); end
        RST = 1'b1;
        last_rd = 32'h0;
    endtask

    task automatic test_fill();
        int lat, bc, ac, ex; logic [31:0] rd; logic e; int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            mem_m[i] = $urandom;
            access(0, 1'b1, 32'(i * 4), mem_m[i], 4'hF, lat, bc, ac, ex, rd, e);
            if (e !== 1'b0 || ac != 1) bad++;
        end
        cmp_cnt++; if (bad != 0) begin fail_cnt++; $display("FAIL fill_writes: got %0d bad acks want 0", bad); end
    endtask

    task automatic test_write_read();
        int lat, bc, ac, ex; logic [31:0] rd; logic e;
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, bc, ac, ex, rd, e);
        mem_m[4] = 32'hDEAD_BEEF;
        cmp_cnt++; if (lat != 2) begin fail_cnt++; $display("FAIL wr_latency: got %0d want 2", lat); end
        cmp_cnt++; if (bc != 3) begin fail_cnt++; $display("FAIL wr_busy_cycles: got %0d want 3", bc); end
        cmp_cnt++; if (ac != 1) begin fail_cnt++; $display("FAIL wr_ack_count: got %0d want 1", ac); end
        cmp_cnt++; if (e !== 1'b0 || ex != 0) begin fail_cnt++; $display("FAIL wr_err: got %b/%0d want 0/0", e, ex); end
        cmp_cnt++; if (rd !== last_rd) begin fail_cnt++; $display("FAIL wr_rdata_hold: got %h want %h", rd, last_rd); end
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (rd !== 32'hDEAD_BEEF) begin fail_cnt++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        cmp_cnt++; if (lat != 2) begin fail_cnt++; $display("FAIL rd_latency: got %0d want 2", lat); end
        last_rd = 32'hDEAD_BEEF;
    endtask

    task automatic test_byte_write();
        int lat, bc, ac, ex; logic [31:0] rd; logic e;
        access(0, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, lat, bc, ac, ex, rd, e);
        mem_m[4] = merge(mem_m[4], 32'h0000_AA00, 4'b0010);
        cmp_cnt++; if (rd !== last_rd) begin fail_cnt++; $display("FAIL bw_rdata_hold: got %h want %h", rd, last_rd); end
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (rd !== 32'hDEAD_AAEF) begin fail_cnt++; $display("FAIL bw_read: got %h want deadaaef", rd); end
        last_rd = rd;
        access(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (ac != 1 || e !== 1'b0) begin fail_cnt++; $display("FAIL be0_ack: got acks %0d err %b want 1/0", ac, e); end
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (rd !== mem_m[4]) begin fail_cnt++; $display("FAIL be0_noop: got %h want %h", rd, mem_m[4]); end
        last_rd = rd;
    endtask

    task automatic test_fault();
        int lat, bc, ac, ex; logic [31:0] rd; logic e;
        access(0, 1'b0, 32'h11, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (e !== 1'b1 || rd !== 32'h0 || lat != 2) begin fail_cnt++; $display("FAIL fault_misaligned: got err %b rdata %h lat %0d want 1/0/2", e, rd, lat); end
        cmp_cnt++; if (ex != 0) begin fail_cnt++; $display("FAIL fault_err_without_ack: got %0d want 0", ex); end
        access(0, 1'b0, 32'h100, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (e !== 1'b1 || rd !== 32'h0) begin fail_cnt++; $display("FAIL fault_range: got err %b rdata %h want 1/0", e, rd); end
        access(0, 1'b1, 32'h12, 32'h1234_5678, 4'hF, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (e !== 1'b1) begin fail_cnt++; $display("FAIL fault_write: got err %b want 1", e); end
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (rd !== mem_m[4] || e !== 1'b0) begin fail_cnt++; $display("FAIL fault_unchanged: got %h err %b want %h/0", rd, e, mem_m[4]); end
        last_rd = rd;
    endtask

    task automatic test_random();
        int lat, bc, ac, ex; logic [31:0] rd, a, d, exp_rd; logic e, w; logic [3:0] b; bit f; int r, wi;
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            wi = $urandom_range(0, 63);
            if (r == 0) a = 32'(wi * 4 + $urandom_range(1, 3));
            else if (r == 1) a = 32'($urandom_range(64, 100000)) * 4;
            else a = 32'(wi * 4);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            f = is_fault(a);
            if (f) exp_rd = 32'h0;
            else if (w) exp_rd = last_rd;
            else exp_rd = mem_m[a / 4];
            access(0, w, a, d, b, lat, bc, ac, ex, rd, e);
            cmp_cnt++; if (rd !== exp_rd) begin fail_cnt++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rd, exp_rd); end
            cmp_cnt++; if (e !== f || lat != 2 || ac != 1 || ex != 0) begin fail_cnt++; $display("FAIL rand_ctrl[%0d]: got err %b lat %0d acks %0d want %b/2/1", n, e, lat, ac, f); end
            if (!f && w) mem_m[a / 4] = merge(mem_m[a / 4], d, b);
            last_rd = exp_rd;
        end
    endtask

    task automatic test_back_to_back();
        bit exp_ack, exp_busy;
        we = 1'b0; be = 4'h0; addr = 32'(8 * 4); req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK); #1;
            exp_ack  = (k % 4 == 2);
            exp_busy = (k % 4 != 3);
            cmp_cnt++; if (ack !== exp_ack || busy !== exp_busy) begin fail_cnt++; $display("FAIL b2b_ack[%0d]: got ack %b busy %b want %b/%b", k, ack, busy, exp_ack, exp_busy); end
            if (exp_ack) begin
                cmp_cnt++; if (rdata !== mem_m[k - 2 + 8]) begin fail_cnt++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata, mem_m[k - 2 + 8]); end
            end
            addr = 32'((k + 1 + 8) * 4);
        end
        req = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        cmp_cnt++; if (busy !== 1'b0 || rdata !== mem_m[24]) begin fail_cnt++; $display("FAIL b2b_drain: got busy %b rdata %h want 0/%h", busy, rdata, mem_m[24]); end
        last_rd = mem_m[24];
    endtask

    task automatic test_reset_mid();
        int lat, bc, ac, ex, acks; logic [31:0] rd; logic e;
        we = 1'b1; addr = 32'h20; wdata = ~mem_m[8]; be = 4'hF; req = 1'b1;
        @(posedge CLK); #1;
        req = 1'b0;
        cmp_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        RST = 1'b0;
        #1;
        cmp_cnt++; if ({busy, ack, err} !== 3'b000 || rdata !== 32'h0) begin fail_cnt++; $display("FAIL rstmid_outputs: got %b rdata %h want 000/0", {busy, ack, err}, rdata); end
        @(posedge CLK); #1;
        RST = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            if (ack) acks++;
        end
        cmp_cnt++; if (acks != 0) begin fail_cnt++; $display("FAIL rstmid_no_ack: got %0d want 0", acks); end
        access(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (rd !== mem_m[8]) begin fail_cnt++; $display("FAIL rstmid_no_commit: got %h want %h", rd, mem_m[8]); end
        last_rd = rd;
    endtask

    task automatic test_wc0();
        int lat, bc, ac, ex; logic [31:0] rd, d; logic e;
        d = $urandom;
        access(1, 1'b1, 32'h0C, d, 4'hF, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (lat != 0 || bc != 1 || ac != 1) begin fail_cnt++; $display("FAIL wc0_write_timing: got lat %0d busy %0d acks %0d want 0/1/1", lat, bc, ac); end
        access(1, 1'b0, 32'h0C, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (lat != 0 || bc != 1) begin fail_cnt++; $display("FAIL wc0_read_timing: got lat %0d busy %0d want 0/1", lat, bc); end
        cmp_cnt++; if (rd !== d || e !== 1'b0) begin fail_cnt++; $display("FAIL wc0_rdata: got %h err %b want %h/0", rd, e, d); end
        access(1, 1'b0, 32'h101, 32'h0, 4'h0, lat, bc, ac, ex, rd, e);
        cmp_cnt++; if (e !== 1'b1 || rd !== 32'h0) begin fail_cnt++; $display("FAIL wc0_fault: got err %b rdata %h want 1/0", e, rd); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_byte_write();
        test_fault();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_wc0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
